dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
//
// PURPOSE
//   Shares the single-ported synchronous data memory between two requesters:
//   - the pipeline MEM stage (core: loads and stores);
//   - the debug/testbench read port (dbg: read-only).
//   The core normally wins. A starvation counter guarantees the debug port one
//   slot after MaxDbgWait cycles of waiting. stall_o feeds the hazard unit so
//   that the pipeline freezes while the core is denied.
//
// PARAMETERS
//   XLEN        32  data width; byte-enable width is XLEN/8
//   AW          32  byte-address width of both requesters
//   MaxDbgWait  4   debug wait cycles before debug pre-empts core (>=1)
//
// PORTS
//   clk_i         in   1        system clock, rising edge
//   rst_i         in   1        asynchronous, active-high reset
//   core_req_i    in   1        core access request; held until granted
//   core_we_i     in   1        1 = store, 0 = load
//   core_be_i     in   XLEN/8   store byte enables
//   core_addr_i   in   AW       core byte address
//   core_wdata_i  in   XLEN     store data
//   core_gnt_o    out  1        core access issued this cycle
//   core_rvalid_o out  1        response for the core access granted last cycle
//   core_rdata_o  out  XLEN     load data; 0 for a store response
//   dbg_req_i     in   1        debug read request; held until granted
//   dbg_addr_i    in   AW       debug byte address
//   dbg_gnt_o     out  1        debug read issued this cycle
//   dbg_rvalid_o  out  1        response for the debug read granted last cycle
//   dbg_rdata_o   out  XLEN     debug read data
//   mem_en_o      out  1        memory access strobe
//   mem_we_o      out  1        memory write enable
//   mem_be_o      out  XLEN/8   memory byte enables
//   mem_addr_o    out  AW-2     word address = granted addr[AW-1:2]
//   mem_wdata_o   out  XLEN     memory write data
//   mem_rdata_i   in   XLEN     memory read data, one cycle after mem_en_o
//   stall_o       out  1        core_req_i & ~core_gnt_o
//
// BEHAVIOUR
//   Arbitration (combinational, every cycle):
//   - Grant goes to dbg if dbg_req_i & (wait_q==MaxDbgWait | ~core_req_i);
//     otherwise to core if core_req_i.
//   - At most one grant per cycle. Back-to-back grants every cycle are allowed.
//   - mem_* outputs mux the granted requester. mem_en_o = core_gnt_o | dbg_gnt_o.
//   - For a dbg grant: mem_we_o=0, mem_be_o=0, mem_wdata_o=0.
//   - With no grant, all mem_* outputs are 0.
//
//   Response tracking (registered):
//   - owner_q : arb_owner_e {OWN_NONE, OWN_CORE, OWN_DBG}.
//     Next value = owner of this cycle's grant, or OWN_NONE.
//   - rd_q : 1 when the granted access is a read.
//   - core_rvalid_o = (owner_q==OWN_CORE). It pulses for stores too (ack).
//   - dbg_rvalid_o  = (owner_q==OWN_DBG).
//   - *_rdata_o = mem_rdata_i when that owner holds owner_q and rd_q=1; else 0.
//   - Latency is exactly 1 cycle from grant to rvalid.
//   - A new grant in the rvalid cycle is legal.
//
//   Starvation counter wait_q, range 0..MaxDbgWait:
//   - Clears on dbg_gnt_o or when dbg_req_i=0.
//   - Otherwise increments while dbg_req_i=1, saturating at MaxDbgWait.
//   - The pre-empting grant clears it.
//   - The core keeps stall_o=1 in that cycle.
//
//   Simultaneous events: core and dbg request with wait_q<MaxDbgWait -> core wins.
//
//   Protocol errors:
//   - A requester dropping or changing a request before grant is a protocol error.
//   - No recovery logic. A bench assertion flags it.
//
//   Reset (asynchronous, may hit mid-operation):
//   - Forces owner_q=OWN_NONE, rd_q=0, wait_q=0.
//   - While rst_i=1, every output is 0, including gnt, mem_en_o and stall_o.
//   - A pending response is dropped; no rvalid appears after reset release.
//
// STRUCTURE
//   - riscv_pkg gets typedef enum logic [1:0] arb_owner_e {OWN_NONE, OWN_CORE, OWN_DBG}.
//   - The counter width comes from $clog2(MaxDbgWait+1) locally.
//   - One sub-module: arb_starve_ctr, the saturating wait counter.
//     Ports: clk_i, rst_i, inc_i, clr_i, sat_o.
//   - Everything else lives in this file: one always_comb for the grant/mux,
//     one always_ff for owner_q and rd_q.
//
// TESTING
//   1. Core load only: addr 0x0000_0010 with mem word 0x4 = 0xDEAD_BEEF.
//      -> core_gnt_o=1 in cycle 0, mem_addr_o=0x4.
//      -> core_rvalid_o=1 and core_rdata_o=0xDEAD_BEEF in cycle 1; stall_o=0.
//   2. Core store: we=1, be=4'b0011, addr 0x20, wdata 0x1234_5678.
//      -> mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=0x8.
//      -> next cycle core_rvalid_o=1 and core_rdata_o=0.
//   3. Both request in the same cycle (MaxDbgWait=4), core requesting continuously.
//      -> core granted cycles 0-3; dbg granted in cycle 4 with stall_o=1.
//      -> dbg_rvalid_o in cycle 5; core granted again in cycle 5.
//   4. Core idle, dbg read at 0x40.
//      -> dbg_gnt_o immediately, mem_we_o=0.
//      -> dbg_rvalid_o=1 next cycle with the word at index 0x10.
//   5. Ten back-to-back core loads to consecutive words.
//      -> ten grants and ten rvalids, each offset by 1 cycle, no gaps.
//   6. rst_i asserted in the cycle after a core grant.
//      -> no core_rvalid_o, all outputs 0, wait_q=0.
//      -> first request after release is granted normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory port arbiter.
//   arb_owner_e : which requester owns the access issued last cycle, and
//                 therefore which one receives the response this cycle.
package riscv_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter used to bound how long the debug port can be
// starved by the core.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, clears the count
//   inc_i  : debug still waiting this cycle, count up (saturating)
//   clr_i  : debug granted or not requesting, count returns to zero
//   sat_o  : count has reached MaxDbgWait, debug must win next arbitration
module arb_starve_ctr #(
    parameter int MaxDbgWait = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int              CW     = $clog2(MaxDbgWait + 1);
    localparam logic [CW-1:0]   MaxCnt = CW'(MaxDbgWait);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (inc_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported synchronous data memory between the pipeline MEM
// stage (loads/stores) and a read-only debug port. The core normally wins;
// after MaxDbgWait cycles of waiting the debug port pre-empts it for one slot.
//   core_*  : core request/grant/response (response 1 cycle after grant)
//   dbg_*   : debug read request/grant/response (response 1 cycle after grant)
//   mem_*   : memory strobe, write enable, byte enables, word address, data
//   stall_o : core is requesting but not granted this cycle
module dmem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 32,
    parameter int MaxDbgWait = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [XLEN/8-1:0] core_be_i,
    input  logic [AW-1:0]     core_addr_i,
    input  logic [XLEN-1:0]   core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [XLEN-1:0]   core_rdata_o,
    input  logic              dbg_req_i,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [XLEN-1:0]   dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [AW-3:0]     mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              stall_o
);

    localparam int BW = XLEN / 8;

    arb_owner_e owner_q;
    arb_owner_e owner_d;
    logic       rd_q;
    logic       rd_d;
    logic       sat_s;
    logic       unused_addr_bits_s;

    // Byte offsets inside a word never reach the memory; the core expresses
    // sub-word stores through core_be_i instead.
    assign unused_addr_bits_s = ^{core_addr_i[1:0], dbg_addr_i[1:0]};

    arb_starve_ctr #(
        .MaxDbgWait (MaxDbgWait)
    ) u_starve_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (dbg_req_i & ~dbg_gnt_o),
        .clr_i (dbg_gnt_o | ~dbg_req_i),
        .sat_o (sat_s)
    );

    // Arbitration and memory-port mux; reset forces every strobe low so the
    // memory sees no access while the block is held in reset.
    always_comb begin
        core_gnt_o  = 1'b0;
        dbg_gnt_o   = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = {BW{1'b0}};
        mem_addr_o  = {(AW-2){1'b0}};
        mem_wdata_o = {XLEN{1'b0}};
        owner_d     = OWN_NONE;
        rd_d        = 1'b0;
        if (rst_i) begin
            owner_d = OWN_NONE;
        end else if (dbg_req_i && (sat_s || !core_req_i)) begin
            // Debug wins when the core is idle or debug has waited long enough.
            dbg_gnt_o  = 1'b1;
            mem_en_o   = 1'b1;
            mem_addr_o = dbg_addr_i[AW-1:2];
            owner_d    = OWN_DBG;
            rd_d       = 1'b1;
        end else if (core_req_i) begin
            core_gnt_o  = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = core_we_i;
            mem_be_o    = core_be_i;
            mem_addr_o  = core_addr_i[AW-1:2];
            mem_wdata_o = core_wdata_i;
            owner_d     = OWN_CORE;
            rd_d        = ~core_we_i;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Remember who owns the in-flight access so its response is routed back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWN_NONE;
            rd_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
        end
    end

    assign stall_o       = core_req_i & ~core_gnt_o & ~rst_i;
    assign core_rvalid_o = (owner_q == OWN_CORE);
    assign dbg_rvalid_o  = (owner_q == OWN_DBG);
    // Store acknowledgements return zero data rather than stale memory output.
    assign core_rdata_o  = ((owner_q == OWN_CORE) && rd_q) ? mem_rdata_i : {XLEN{1'b0}};
    assign dbg_rdata_o   = ((owner_q == OWN_DBG)  && rd_q) ? mem_rdata_i : {XLEN{1'b0}};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model (shadow memory, pending-response slot, wait counter).
module tb_dmem_port_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int MAXW = 4;
    localparam int BW   = XLEN / 8;

    logic            clk_i        = 1'b0;
    logic            rst_i        = 1'b1;
    logic            core_req_i   = 1'b0;
    logic            core_we_i    = 1'b0;
    logic [BW-1:0]   core_be_i    = 4'd0;
    logic [AW-1:0]   core_addr_i  = 32'd0;
    logic [XLEN-1:0] core_wdata_i = 32'd0;
    logic            dbg_req_i    = 1'b0;
    logic [AW-1:0]   dbg_addr_i   = 32'd0;
    logic [XLEN-1:0] mem_rdata_i  = 32'd0;
    logic            core_gnt_o, core_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
    logic [XLEN-1:0] core_rdata_o, dbg_rdata_o, mem_wdata_o;
    logic            mem_en_o, mem_we_o, stall_o;
    logic [BW-1:0]   mem_be_o;
    logic [AW-3:0]   mem_addr_o;

    int checks = 0;
    int errors = 0;
    logic preload = 1'b1;

    always #5 clk_i = ~clk_i;

    dmem_port_arbiter #(.XLEN(XLEN), .AW(AW), .MaxDbgWait(MAXW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_be_i    (core_be_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_gnt_o    (dbg_gnt_o),
        .dbg_rvalid_o (dbg_rvalid_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .stall_o      (stall_o)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(i * 257);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous 64-word RAM on the memory side of the arbiter.
    logic [31:0] ram [0:63];
    always @(posedge clk_i) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (mem_en_o) begin
            mem_rdata_i <= ram[mem_addr_o[5:0]];
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[5:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    // Behavioural model state.
    logic [31:0] shadow [0:63];
    int          wait_m     = 0;
    int          pend_owner = 0;     // 0 none, 1 core, 2 debug
    logic [31:0] pend_data  = 32'd0;
    logic        m_core_gnt = 1'b0;
    logic        m_dbg_gnt  = 1'b0;

    // Every-cycle comparison of the DUT against the model, then model advance.
    always @(negedge clk_i) begin : model
        logic ec, ed;
        logic [5:0] idx;
        logic [31:0] w;
        if (rst_i) begin
            if (preload) for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
            chk("rst_ctl", 64'({core_gnt_o, dbg_gnt_o, stall_o, mem_en_o, mem_we_o, mem_be_o,
                                core_rvalid_o, dbg_rvalid_o}), 64'd0);
            chk("rst_mem", 64'({mem_addr_o, mem_wdata_o}), 64'd0);
            chk("rst_rdata", 64'({core_rdata_o, dbg_rdata_o}), 64'd0);
            wait_m = 0; pend_owner = 0; m_core_gnt = 1'b0; m_dbg_gnt = 1'b0;
        end else begin
            ed = dbg_req_i && ((wait_m == MAXW) || !core_req_i);
            ec = core_req_i && !ed;
            chk("grant", 64'({core_gnt_o, dbg_gnt_o, stall_o}), 64'({ec, ed, core_req_i && !ec}));
            if (ec) begin
                chk("mem_ctl", 64'({mem_en_o, mem_we_o, mem_be_o}), 64'({1'b1, core_we_i, core_be_i}));
                chk("mem_addr", 64'(mem_addr_o), 64'(core_addr_i[31:2]));
                chk("mem_wdata", 64'(mem_wdata_o), 64'(core_wdata_i));
            end else if (ed) begin
                chk("mem_ctl", 64'({mem_en_o, mem_we_o, mem_be_o}), 64'({1'b1, 1'b0, 4'd0}));
                chk("mem_addr", 64'(mem_addr_o), 64'(dbg_addr_i[31:2]));
                chk("mem_wdata", 64'(mem_wdata_o), 64'd0);
            end else begin
                chk("mem_idle", 64'({mem_en_o, mem_we_o, mem_be_o}), 64'd0);
                chk("mem_idle_bus", 64'({mem_addr_o, mem_wdata_o}), 64'd0);
            end
            chk("core_rsp", 64'({core_rvalid_o, core_rdata_o}),
                64'({pend_owner == 1, (pend_owner == 1) ? pend_data : 32'd0}));
            chk("dbg_rsp", 64'({dbg_rvalid_o, dbg_rdata_o}),
                64'({pend_owner == 2, (pend_owner == 2) ? pend_data : 32'd0}));
            pend_owner = 0;
            if (ec) begin
                idx = core_addr_i[7:2];
                pend_owner = 1;
                pend_data = core_we_i ? 32'd0 : shadow[idx];
                if (core_we_i) begin
                    w = shadow[idx];
                    for (int b = 0; b < BW; b++)
                        if (core_be_i[b]) w[8*b +: 8] = core_wdata_i[8*b +: 8];
                    shadow[idx] = w;
                end
            end else if (ed) begin
                pend_owner = 2;
                pend_data = shadow[dbg_addr_i[7:2]];
            end
            if (ed || !dbg_req_i) wait_m = 0;
            else if (wait_m < MAXW) wait_m++;
            m_core_gnt = ec;
            m_dbg_gnt  = ed;
        end
    end

    task automatic at_pos();
        @(posedge clk_i); #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i); #1;
    endtask

    task automatic core_rd(logic [31:0] a);
        core_req_i = 1'b1; core_we_i = 1'b0; core_be_i = 4'd0; core_addr_i = a; core_wdata_i = 32'd0;
    endtask

    initial begin
        repeat (3) at_pos();
        preload = 1'b0;
        rst_i = 1'b0;

        // 1. core load of word 4
        core_rd(32'h0000_0010);
        at_neg();
        chk("t1_gnt", 64'({core_gnt_o, stall_o}), 64'b10);
        chk("t1_addr", 64'(mem_addr_o), 64'h4);
        // 2. store issued in the load's response cycle
        at_pos();
        core_req_i = 1'b1; core_we_i = 1'b1; core_be_i = 4'b0011;
        core_addr_i = 32'h20; core_wdata_i = 32'h1234_5678;
        at_neg();
        chk("t1_rsp", 64'({core_rvalid_o, core_rdata_o}), 64'h1_DEAD_BEEF);
        chk("t2_ctl", 64'({mem_we_o, mem_be_o}), 64'b1_0011);
        chk("t2_addr", 64'(mem_addr_o), 64'h8);
        at_pos();
        core_req_i = 1'b0; core_we_i = 1'b0;
        at_neg();
        chk("t2_rsp", 64'({core_rvalid_o, core_rdata_o}), 64'h1_0000_0000);

        // 3. starvation: core continuous, debug pre-empts after MAXW cycles
        at_pos();
        core_rd(32'h10);
        dbg_req_i = 1'b1; dbg_addr_i = 32'h40;
        for (int c = 0; c <= MAXW; c++) begin
            at_neg();
            chk("t3_gnt", 64'({core_gnt_o, dbg_gnt_o, stall_o}),
                64'({c < MAXW, c == MAXW, c == MAXW}));
            at_pos();
            if (c == MAXW) dbg_req_i = 1'b0;
        end
        at_neg();
        chk("t3_dbg_rsp", 64'({dbg_rvalid_o, dbg_rdata_o}), 64'({1'b1, init_word(16)}));
        chk("t3_core_again", 64'(core_gnt_o), 64'd1);
        at_pos();
        core_req_i = 1'b0;

        // 4. debug read with the core idle
        at_pos();
        dbg_req_i = 1'b1; dbg_addr_i = 32'h40;
        at_neg();
        chk("t4_gnt", 64'({dbg_gnt_o, mem_we_o}), 64'b10);
        chk("t4_addr", 64'(mem_addr_o), 64'h10);
        at_pos();
        dbg_req_i = 1'b0;
        at_neg();
        chk("t4_rsp", 64'({dbg_rvalid_o, dbg_rdata_o}), 64'({1'b1, init_word(16)}));

        // 5. ten back-to-back core loads
        for (int i = 0; i < 10; i++) begin
            at_pos();
            core_rd(32'h80 + 32'(4 * i));
            at_neg();
            chk("t5_gnt", 64'(core_gnt_o), 64'd1);
            if (i > 0) chk("t5_rsp", 64'({core_rvalid_o, core_rdata_o}), 64'({1'b1, init_word(32 + i - 1)}));
        end
        at_pos();
        core_req_i = 1'b0;
        at_neg();
        chk("t5_last", 64'({core_rvalid_o, core_rdata_o}), 64'({1'b1, init_word(41)}));

        // 6. reset in the cycle after a core grant
        at_pos();
        core_rd(32'h10);
        dbg_req_i = 1'b1; dbg_addr_i = 32'h44;
        at_neg();
        chk("t6_gnt", 64'(core_gnt_o), 64'd1);
        at_pos();
        core_rd(32'h14);
        #2 rst_i = 1'b1;
        at_neg();
        chk("t6_rst", 64'({core_rvalid_o, core_gnt_o, dbg_gnt_o, stall_o, mem_en_o}), 64'd0);
        at_pos();
        rst_i = 1'b0;
        at_neg();
        chk("t6_release", 64'({core_rvalid_o, core_gnt_o, dbg_gnt_o}), 64'b010);
        at_pos();
        core_req_i = 1'b0;
        at_neg();
        chk("t6_next", 64'({dbg_gnt_o, core_rvalid_o, core_rdata_o}), 64'({2'b11, init_word(5)}));
        at_pos();
        dbg_req_i = 1'b0;

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            at_pos();
            if (!core_req_i || m_core_gnt) begin
                core_req_i   = ($urandom_range(0, 99) < 65);
                core_we_i    = 1'($urandom_range(0, 1));
                core_be_i    = 4'($urandom_range(0, 15));
                core_addr_i  = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                core_wdata_i = $urandom;
            end
            if (!dbg_req_i || m_dbg_gnt) begin
                dbg_req_i  = ($urandom_range(0, 99) < 40);
                dbg_addr_i = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            end
            if (rst_i) rst_i = 1'b0;
            else if ($urandom_range(0, 249) == 0) begin
                #2 rst_i = 1'b1;
            end
        end
        at_pos();
        rst_i = 1'b0; core_req_i = 1'b0; dbg_req_i = 1'b0;
        repeat (2) at_pos();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
